// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

  localparam int unsigned ADDR_W             = 16;
  localparam int unsigned DATA_W             = 32;
  localparam int unsigned NB_W               = 8;
  localparam int unsigned SHA256_BLOCK_WORDS = 16;
  localparam int unsigned BLOCK_SHIFT        = $clog2(SHA256_BLOCK_WORDS);

  localparam logic [DATA_W-1:0] SHA256_PAD_WORD = 32'h8000_0000;
  localparam logic [ADDR_W-1:0] MAX_WORDS       = 16'd2032;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    PAD,
    DONE
  } padder_state_e;

  // Blocks needed for a message plus the 0x80 word and two length words.
  function automatic logic [NB_W-1:0] blocks_for_words(input logic [ADDR_W-1:0] words);
    logic [ADDR_W:0] total;
    total = (ADDR_W+1)'(words) + (ADDR_W+1)'(3) + (ADDR_W+1)'(SHA256_BLOCK_WORDS - 1);
    return NB_W'(total >> BLOCK_SHIFT);
  endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Control and memory-port bundle between the padder and its environment.
interface sha256_msg_padder_if;
  import sha256_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] message_addr;
  logic [ADDR_W-1:0] output_addr;
  logic [ADDR_W-1:0] msg_words;
  logic              done;
  logic [NB_W-1:0]   num_blocks;
  logic              mem_clk;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    input  start, message_addr, output_addr, msg_words, mem_read_data,
    output done, num_blocks, mem_clk, mem_we, mem_addr, mem_write_data
  );

  modport slave (
    output start, message_addr, output_addr, msg_words, mem_read_data,
    input  done, num_blocks, mem_clk, mem_we, mem_addr, mem_write_data
  );

endinterface

// File: rtl/sha256_pad_word_gen.sv
// Combinational pad/length word for position idx of the padded output.
module sha256_pad_word_gen
  import sha256_pkg::*;
(
  input  logic [ADDR_W-1:0] idx,
  input  logic [ADDR_W-1:0] msg_words,
  input  logic [ADDR_W-1:0] out_words,
  output logic [DATA_W-1:0] pad_word_c
);

  logic [63:0] len_bits;

  assign len_bits = 64'(msg_words) << 5;

  // Marker word sits right after the message; length occupies the last two words.
  always_comb begin
    pad_word_c = '0;
    if (idx == msg_words) begin
      pad_word_c = SHA256_PAD_WORD;
    end else if (idx == out_words - ADDR_W'(2)) begin
      pad_word_c = len_bits[63:32];
    end else if (idx == out_words - ADDR_W'(1)) begin
      pad_word_c = len_bits[31:0];
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// Copies a message word by word, then appends SHA-256 padding and bit length.
// Optional SHA256_PADDER_BSWAP_EN: byte-reverse copied message words.
module sha256_msg_padder
  import sha256_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  sha256_msg_padder_if.master       bus
);

  padder_state_e     state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] msg_addr_q, msg_addr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [ADDR_W-1:0] msg_words_q, msg_words_d;
  logic [NB_W-1:0]   num_blocks_q, num_blocks_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] req_words_c;
  logic [ADDR_W-1:0] out_words_c;
  logic [ADDR_W-1:0] idx_inc_c;
  logic [DATA_W-1:0] pad_word_c;
  logic [DATA_W-1:0] copy_word_c;

  assign req_words_c = (bus.msg_words > MAX_WORDS) ? MAX_WORDS : bus.msg_words;
  assign out_words_c = ADDR_W'(num_blocks_q) << BLOCK_SHIFT;
  assign idx_inc_c   = idx_q + ADDR_W'(1);

`ifdef SHA256_PADDER_BSWAP_EN
  assign copy_word_c = {bus.mem_read_data[7:0],   bus.mem_read_data[15:8],
                        bus.mem_read_data[23:16], bus.mem_read_data[31:24]};
`else
  assign copy_word_c = bus.mem_read_data;
`endif

  sha256_pad_word_gen u_pad_word_gen (
    .idx        (idx_q),
    .msg_words  (msg_words_q),
    .out_words  (out_words_c),
    .pad_word_c (pad_word_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      msg_addr_q   <= '0;
      out_addr_q   <= '0;
      msg_words_q  <= '0;
      num_blocks_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      msg_addr_q   <= msg_addr_d;
      out_addr_q   <= out_addr_d;
      msg_words_q  <= msg_words_d;
      num_blocks_q <= num_blocks_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
    end
  end

  // Read data for an address registered in RD arrives in time for WR's edge.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    msg_addr_d   = msg_addr_q;
    out_addr_d   = out_addr_q;
    msg_words_d  = msg_words_q;
    num_blocks_d = num_blocks_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    wdata_d      = wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          msg_addr_d   = bus.message_addr;
          out_addr_d   = bus.output_addr;
          msg_words_d  = req_words_c;
          num_blocks_d = blocks_for_words(req_words_c);
          idx_d        = '0;
          state_d      = (req_words_c != '0) ? RD : PAD;
        end
      end
      RD: begin
        mem_addr_d = msg_addr_q + idx_q;
        state_d    = WAIT;
      end
      WAIT: begin
        state_d = WR;
      end
      WR: begin
        mem_we_d   = 1'b1;
        mem_addr_d = out_addr_q + idx_q;
        wdata_d    = copy_word_c;
        idx_d      = idx_inc_c;
        state_d    = (idx_inc_c < msg_words_q) ? RD : PAD;
      end
      PAD: begin
        mem_we_d   = 1'b1;
        mem_addr_d = out_addr_q + idx_q;
        wdata_d    = pad_word_c;
        idx_d      = idx_inc_c;
        if (idx_q == out_words_c - ADDR_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!bus.start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE);
  end

  assign bus.done           = done_q;
  assign bus.num_blocks     = num_blocks_q;
  assign bus.mem_clk        = clk;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_write_data = wdata_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder with a byte-level SHA-256 padding model.
module tb_sha256_msg_padder;
  import sha256_pkg::*;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  sha256_msg_padder_if bus();

  sha256_msg_padder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Word memory: one cycle registered read, write-first preload port for the bench.
  logic [31:0] mem [0:65535];
  logic [31:0] rd_q = '0;
  logic        tb_we = 1'b0;
  logic [15:0] tb_addr = '0;
  logic [31:0] tb_data = '0;

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_write_data;
    else if (tb_we) mem[tb_addr] <= tb_data;
    rd_q <= mem[bus.mem_addr];
  end

  assign bus.mem_read_data = rd_q;

  wr_t exp_q[$];
  wr_t mon_e;
  bit  count_post = 1'b0;
  int  post_writes = 0;

  // Every DUT write must match the next expected write in order.
  always @(negedge clk) begin
    if (reset_n && bus.mem_we) begin
      if (count_post) post_writes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got %h:%h want none", bus.mem_addr, bus.mem_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.addr !== bus.mem_addr || mon_e.data !== bus.mem_write_data) begin
          errors++;
          $display("FAIL write got %h:%h want %h:%h",
                   bus.mem_addr, bus.mem_write_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Standard SHA-256 padding on a byte stream, then packed back into words.
  task automatic pad_model(input logic [31:0] words[$], output logic [31:0] out[$]);
    logic [7:0]  b[$];
    logic [63:0] bits;
    logic [31:0] w;
    bits = 64'(words.size()) * 64'd32;
    foreach (words[i]) begin
      w = words[i];
`ifdef SHA256_PADDER_BSWAP_EN
      for (int k = 0; k < 4; k++) b.push_back(w[8*k +: 8]);
`else
      for (int k = 3; k >= 0; k--) b.push_back(w[8*k +: 8]);
`endif
    end
    b.push_back(8'h80);
    while ((b.size() % 64) != 56) b.push_back(8'h00);
    for (int k = 7; k >= 0; k--) b.push_back(bits[8*k +: 8]);
    out = {};
    for (int i = 0; i < b.size(); i += 4) out.push_back({b[i], b[i+1], b[i+2], b[i+3]});
  endtask

  task automatic preload(input logic [15:0] src, input int m, input bit fixed_first,
                         output logic [31:0] words[$]);
    logic [31:0] w;
    words = {};
    for (int i = 0; i < m; i++) begin
      w = (fixed_first && i == 0) ? 32'h1122_3344 : $urandom;
      words.push_back(w);
      @(negedge clk);
      tb_we = 1'b1; tb_addr = 16'(src + 16'(i)); tb_data = w;
    end
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic run(input int m_req, input logic [15:0] src, input logic [15:0] dst,
                     input bit hold, input bit fixed_first);
    logic [31:0] words[$];
    logic [31:0] exp_w[$];
    int m, nb, cycles;
    m = (m_req > int'(MAX_WORDS)) ? int'(MAX_WORDS) : m_req;
    preload(src, m, fixed_first, words);
    pad_model(words, exp_w);
    nb = exp_w.size() / 16;
    check("sb_empty_at_start", exp_q.size(), 0);
    foreach (exp_w[i]) exp_q.push_back('{16'(dst + 16'(i)), exp_w[i]});
    @(negedge clk);
    bus.start = 1'b1; bus.message_addr = src; bus.output_addr = dst; bus.msg_words = 16'(m_req);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!bus.done && cycles < 20000);
    check("done_rise", bus.done, 1);
    check("latency", cycles, 1 + 3*m + (nb*16 - m));
    check("num_blocks", bus.num_blocks, nb);
    if (hold) begin
      repeat (10) @(posedge clk);
      #1;
      check("done_held", bus.done, 1);
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    foreach (exp_w[i]) check("image", mem[16'(dst + 16'(i))], exp_w[i]);
    repeat (2) @(posedge clk);
    #1;
    check("done_fall", bus.done, 0);
    check("sb_drained", exp_q.size(), 0);
  endtask

  task automatic reset_mid_copy(input logic [15:0] src, input logic [15:0] dst);
    logic [31:0] words[$];
    logic [31:0] exp_w[$];
    int cnt;
    preload(src, 20, 1'b0, words);
    pad_model(words, exp_w);
    foreach (exp_w[i]) exp_q.push_back('{16'(dst + 16'(i)), exp_w[i]});
    @(negedge clk);
    bus.start = 1'b1; bus.message_addr = src; bus.output_addr = dst; bus.msg_words = 16'd20;
    cnt = 0;
    while (!(bus.mem_addr == 16'(src + 16'd5) && !bus.mem_we) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("rd5_reached", longint'(cnt < 200), 1);
    check("words_before_reset", exp_q.size(), exp_w.size() - 5);
    bus.start = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_done", bus.done, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    exp_q.delete();
    post_writes = 0;
    count_post = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    check("writes_after_reset", post_writes, 0);
    count_post = 1'b0;
  endtask

  logic [31:0] bswap_want;
  logic [15:0] rsrc;

  initial begin
    bus.start = 1'b0; bus.message_addr = '0; bus.output_addr = '0; bus.msg_words = '0;
    repeat (3) @(negedge clk);
    check("reset_done", bus.done, 0);
    check("reset_mem_we", bus.mem_we, 0);
    check("reset_mem_addr", bus.mem_addr, 0);
    check("reset_wdata", bus.mem_write_data, 0);
    check("reset_num_blocks", bus.num_blocks, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run(20, 16'h0100, 16'h1000, 1'b0, 1'b0);
    check("nb_20", bus.num_blocks, 2);
    check("len_20", mem[16'h1000 + 16'd31], 640);
    run(13, 16'h0200, 16'h1100, 1'b0, 1'b0);
    check("len_13", mem[16'h1100 + 16'd15], 416);
    run(14, 16'h0300, 16'h1200, 1'b0, 1'b0);
    check("len_14", mem[16'h1200 + 16'd31], 448);
    run(0, 16'h0400, 16'h1300, 1'b0, 1'b0);
    check("marker_0", mem[16'h1300], 32'h8000_0000);

    reset_mid_copy(16'h0500, 16'h1400);
    run(20, 16'h0500, 16'h1400, 1'b0, 1'b0);

`ifdef SHA256_PADDER_BSWAP_EN
    bswap_want = 32'h4433_2211;
`else
    bswap_want = 32'h1122_3344;
`endif
    run(1, 16'h0600, 16'h1500, 1'b1, 1'b1);
    check("first_word_order", mem[16'h1500], bswap_want);

    run(30, 16'h3000, 16'h2FFE, 1'b0, 1'b0);
    run(30, 16'h3100, 16'h3100, 1'b0, 1'b0);
    run(20, 16'hFFF8, 16'h7FF4, 1'b0, 1'b0);
    run(2040, 16'h8000, 16'hA000, 1'b0, 1'b0);
    check("nb_clamped", bus.num_blocks, 128);

    for (int r = 0; r < 6; r++) begin
      rsrc = 16'($urandom);
      run(int'($urandom_range(0, 40)), rsrc, 16'(rsrc + 16'h4000), 1'(r % 2), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

endmodule
